// File: rtl/mure_pkg.sv
// Shared micro-op retirement types: lane entry, instruction class and the
// four-lane retirement bundle stored by the bundle FIFO.
package mure_pkg;

   localparam int unsigned NrRetiredInstr = 4;

   typedef enum logic [2:0] {
      STD,
      EXC,
      INT,
      ERET,
      UIJ
   } itype_e;

   typedef struct packed {
      itype_e      itype;
      logic [31:0] pc;
      logic [31:0] tval;
   } uop_entry_s;

   // Lane index NrRetiredInstr-1 is lane a (oldest), index 0 is lane d.
   typedef struct packed {
      logic [NrRetiredInstr-1:0]       ivalids;
      uop_entry_s [NrRetiredInstr-1:0] lane;
   } uop_bundle_s;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Wrap-bit read/write pointer pair with full/empty/usage generation and
// flush-first push/pop qualification.
module fifo_ptr_ctrl #(
   parameter int unsigned Depth = 8,
   parameter int unsigned CntW  = $clog2(Depth) + 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_req_i,
   input  logic                     pop_req_i,
   output logic                     push_o,
   output logic                     pop_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(Depth)-1:0] widx_o,
   output logic [$clog2(Depth)-1:0] ridx_o,
   output logic [CntW-1:0]          usage_o
);

   localparam int unsigned IdxW = $clog2(Depth);

   logic [IdxW:0] wptr_q, wptr_d;
   logic [IdxW:0] rptr_q, rptr_d;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]) &&
                    (wptr_q[IdxW] != rptr_q[IdxW]);
   assign push_o  = push_req_i & ~full_o & ~flush_i;
   assign pop_o   = pop_req_i & ~empty_o & ~flush_i;
   assign widx_o  = wptr_q[IdxW-1:0];
   assign ridx_o  = rptr_q[IdxW-1:0];
   assign usage_o = wptr_q - rptr_q;

   // Depth is a power of two, so a plain increment wraps the index and
   // toggles the wrap bit together.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push_o) wptr_d = wptr_q + (IdxW+1)'(1);
         if (pop_o)  rptr_d = rptr_q + (IdxW+1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

endmodule

// File: rtl/uop_bundle_fifo.sv
// Retirement bundle FIFO between commit-port sampling and ingress_fsm.
// Optional statistics outputs are enabled by UOP_BUNDLE_FIFO_STATS_EN.
module uop_bundle_fifo
   import mure_pkg::*;
#(
   parameter int unsigned Depth = 8,
   parameter int unsigned CntW  = $clog2(Depth) + 1
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   valid_i,
   input  logic [NrRetiredInstr-1:0]              ivalids_i,
   input  mure_pkg::uop_entry_s [NrRetiredInstr-1:0] uop_i,
   output logic                                   ready_o,
   input  logic                                   flush_i,
   output logic                                   valid_o,
   output logic [NrRetiredInstr-1:0]              ivalids_o,
   output mure_pkg::uop_entry_s                   uop_a_o,
   output mure_pkg::uop_entry_s                   uop_b_o,
   output mure_pkg::uop_entry_s                   uop_c_o,
   output mure_pkg::uop_entry_s                   uop_d_o,
   input  logic                                   pop_i,
   output logic [CntW-1:0]                        usage_o,
`ifdef UOP_BUNDLE_FIFO_STATS_EN
   output logic [15:0]                            drop_cnt_o,
   output logic [CntW-1:0]                        hwm_o,
`endif
   output logic                                   overflow_o
);

   localparam int unsigned IdxW = $clog2(Depth);

   if (NrRetiredInstr != 4) begin : g_bad_lanes
      $error("uop_bundle_fifo supports exactly four retirement lanes");
   end
   if ((Depth < 2) || ((1 << IdxW) != Depth)) begin : g_bad_depth
      $error("uop_bundle_fifo Depth must be a power of two >= 2");
   end
   if (CntW != IdxW + 1) begin : g_bad_cntw
      $error("uop_bundle_fifo CntW must equal $clog2(Depth)+1");
   end

   logic            push_req, push, pop, full, empty, drop;
   logic [IdxW-1:0] widx, ridx;
   uop_bundle_s     mem_q [Depth];
   uop_bundle_s     mem_d [Depth];
   uop_bundle_s     head;
   logic            overflow_q, overflow_d;

   assign push_req = valid_i & (|ivalids_i);
   assign drop     = push_req & full & ~flush_i;

   fifo_ptr_ctrl #(
      .Depth (Depth),
      .CntW  (CntW)
   ) i_ptr_ctrl (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .push_req_i (push_req),
      .pop_req_i  (pop_i),
      .push_o     (push),
      .pop_o      (pop),
      .full_o     (full),
      .empty_o    (empty),
      .widx_o     (widx),
      .ridx_o     (ridx),
      .usage_o    (usage_o)
   );

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[widx] = '{ivalids: ivalids_i, lane: uop_i};
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   always_comb begin
      overflow_d = overflow_q;
      if (flush_i)   overflow_d = 1'b0;
      else if (drop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) overflow_q <= 1'b0;
      else         overflow_q <= overflow_d;
   end

   // Empty FIFO presents an all-zero head so downstream decode sees no retirement.
   assign head       = empty ? '0 : mem_q[ridx];
   assign valid_o    = ~empty;
   assign ready_o    = ~full;
   assign ivalids_o  = head.ivalids;
   assign uop_a_o    = head.lane[3];
   assign uop_b_o    = head.lane[2];
   assign uop_c_o    = head.lane[1];
   assign uop_d_o    = head.lane[0];
   assign overflow_o = overflow_q;

`ifdef UOP_BUNDLE_FIFO_STATS_EN
   logic [15:0]     drop_cnt_q, drop_cnt_d;
   logic [CntW-1:0] hwm_q, hwm_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      hwm_d      = hwm_q;
      if (flush_i) begin
         drop_cnt_d = '0;
         hwm_d      = '0;
      end else begin
         if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
         if (usage_o > hwm_q)            hwm_d      = usage_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_cnt_q <= '0;
         hwm_q      <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         hwm_q      <= hwm_d;
      end
   end

   assign drop_cnt_o = drop_cnt_q;
   assign hwm_o      = hwm_q;
`endif

endmodule

// File: tb/tb_uop_bundle_fifo.sv
// Self-checking bench for uop_bundle_fifo: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_uop_bundle_fifo;
   import mure_pkg::*;

   localparam int unsigned Depth = 8;
   localparam int unsigned CntW  = 4;

   logic                            clk_i = 1'b0;
   logic                            rst_ni;
   logic                            valid_i;
   logic [NrRetiredInstr-1:0]       ivalids_i;
   uop_entry_s [NrRetiredInstr-1:0] uop_i;
   logic                            ready_o;
   logic                            flush_i;
   logic                            valid_o;
   logic [NrRetiredInstr-1:0]       ivalids_o;
   uop_entry_s                      uop_a_o, uop_b_o, uop_c_o, uop_d_o;
   logic                            pop_i;
   logic [CntW-1:0]                 usage_o;
   logic                            overflow_o;
`ifdef UOP_BUNDLE_FIFO_STATS_EN
   logic [15:0]                     drop_cnt_o;
   logic [CntW-1:0]                 hwm_o;
`endif

   uop_bundle_fifo #(
      .Depth (Depth),
      .CntW  (CntW)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .valid_i    (valid_i),
      .ivalids_i  (ivalids_i),
      .uop_i      (uop_i),
      .ready_o    (ready_o),
      .flush_i    (flush_i),
      .valid_o    (valid_o),
      .ivalids_o  (ivalids_o),
      .uop_a_o    (uop_a_o),
      .uop_b_o    (uop_b_o),
      .uop_c_o    (uop_c_o),
      .uop_d_o    (uop_d_o),
      .pop_i      (pop_i),
      .usage_o    (usage_o),
`ifdef UOP_BUNDLE_FIFO_STATS_EN
      .drop_cnt_o (drop_cnt_o),
      .hwm_o      (hwm_o),
`endif
      .overflow_o (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Reference model: the FIFO is just an ordered queue of accepted bundles.
   uop_bundle_s mq[$];
   bit          m_ovf;
   int unsigned m_drops;
   int unsigned m_hwm;

   typedef struct {
      logic        v;
      logic [3:0]  iv;
      logic        pop;
      logic        fl;
      int unsigned usage;
      logic        valid;
      logic [3:0]  exp_iv;
      logic        ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic uop_bundle_s rand_bundle(input logic [3:0] m);
      uop_bundle_s b;
      b.ivalids = m;
      for (int l = 0; l < 4; l++) begin
         b.lane[l].itype = itype_e'($urandom_range(0, 4));
         b.lane[l].pc    = $urandom;
         b.lane[l].tval  = $urandom;
      end
      return b;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
      m_hwm   = 0;
   endtask

   task automatic compare_model();
      uop_bundle_s h;
      h = (mq.size() != 0) ? mq[0] : '0;
      check("usage", 128'(usage_o), 128'(mq.size()));
      check("valid", 128'(valid_o), 128'(mq.size() != 0));
      check("ready", 128'(ready_o), 128'(mq.size() < Depth));
      check("overflow", 128'(overflow_o), 128'(m_ovf));
      check("ivalids", 128'(ivalids_o), 128'(h.ivalids));
      check("uop_a", 128'(uop_a_o), 128'(h.lane[3]));
      check("uop_b", 128'(uop_b_o), 128'(h.lane[2]));
      check("uop_c", 128'(uop_c_o), 128'(h.lane[1]));
      check("uop_d", 128'(uop_d_o), 128'(h.lane[0]));
`ifdef UOP_BUNDLE_FIFO_STATS_EN
      check("drop_cnt", 128'(drop_cnt_o), 128'(m_drops));
      check("hwm", 128'(hwm_o), 128'(m_hwm));
`endif
   endtask

   // Drive one cycle, advance the model across the edge, compare #1 later.
   task automatic do_cycle(input logic v, input logic [3:0] iv, input logic p,
                           input logic fl, input uop_bundle_s b);
      bit full, empty, preq;
      valid_i   = v;
      ivalids_i = iv;
      uop_i     = b.lane;
      pop_i     = p;
      flush_i   = fl;
      @(posedge clk_i);
      if (fl) begin
         model_reset();
      end else begin
         full  = (mq.size() == Depth);
         empty = (mq.size() == 0);
         preq  = v && (iv != 4'b0);
         if (mq.size() > m_hwm) m_hwm = mq.size();
         if (preq && full) begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
         end
         if (p && !empty) void'(mq.pop_front());
         if (preq && !full) mq.push_back(b);
      end
      #1;
      compare_model();
   endtask

   task automatic push(input logic [3:0] m);
      do_cycle(1'b1, m, 1'b0, 1'b0, rand_bundle(m));
   endtask

   task automatic pop1();
      do_cycle(1'b0, 4'b0, 1'b1, 1'b0, '0);
   endtask

   task automatic flush1();
      do_cycle(1'b0, 4'b0, 1'b0, 1'b1, '0);
   endtask

   initial begin
      uop_bundle_s b;
      rst_ni    = 1'b0;
      valid_i   = 1'b0;
      ivalids_i = '0;
      uop_i     = '0;
      pop_i     = 1'b0;
      flush_i   = 1'b0;
      model_reset();

      #22;
      check("rst_usage", 128'(usage_o), 128'(0));
      check("rst_valid", 128'(valid_o), 128'(0));
      check("rst_ready", 128'(ready_o), 128'(1));
      check("rst_overflow", 128'(overflow_o), 128'(0));
      check("rst_ivalids", 128'(ivalids_o), 128'(0));
      check("rst_uop_a", 128'(uop_a_o), 128'(0));
      rst_ni = 1'b1;

      // v, iv, pop, flush -> usage, valid, ivalids, overflow
      vecs[0] = '{1'b1, 4'b1000, 1'b0, 1'b0, 1, 1'b1, 4'b1000, 1'b0};
      vecs[1] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 1'b0};
      vecs[2] = '{1'b1, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000, 1'b0};
      vecs[3] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 1'b0};
      vecs[4] = '{1'b1, 4'b0011, 1'b1, 1'b0, 1, 1'b1, 4'b0011, 1'b0};
      vecs[5] = '{1'b1, 4'b0101, 1'b1, 1'b0, 1, 1'b1, 4'b0101, 1'b0};
      vecs[6] = '{1'b1, 4'b1111, 1'b0, 1'b1, 0, 1'b0, 4'b0000, 1'b0};
      for (int i = 0; i < 7; i++) begin
         b = rand_bundle(vecs[i].iv);
         b.lane[3].itype = EXC;
         do_cycle(vecs[i].v, vecs[i].iv, vecs[i].pop, vecs[i].fl, b);
         check($sformatf("vec%0d_usage", i), 128'(usage_o), 128'(vecs[i].usage));
         check($sformatf("vec%0d_valid", i), 128'(valid_o), 128'(vecs[i].valid));
         check($sformatf("vec%0d_ivalids", i), 128'(ivalids_o), 128'(vecs[i].exp_iv));
         check($sformatf("vec%0d_overflow", i), 128'(overflow_o), 128'(vecs[i].ovf));
         if (i == 0) check("vec0_lane_a_itype", 128'(uop_a_o.itype), 128'(EXC));
      end

      // Fill to full, drop a ninth bundle, drain in order.
      for (int i = 1; i <= 8; i++) push(4'(i));
      check("fill_usage", 128'(usage_o), 128'(8));
      check("fill_ready", 128'(ready_o), 128'(0));
      push(4'b1111);
      check("drop_overflow", 128'(overflow_o), 128'(1));
      check("drop_usage", 128'(usage_o), 128'(8));
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("drain_mask%0d", i), 128'(ivalids_o), 128'(i));
         pop1();
      end
      check("drain_valid", 128'(valid_o), 128'(0));
      flush1();

      // Full with simultaneous push and pop: push dropped, one entry leaves.
      for (int i = 0; i < 8; i++) push(4'($urandom_range(1, 15)));
      do_cycle(1'b1, 4'b1111, 1'b1, 1'b0, rand_bundle(4'b1111));
      check("fullpp_usage", 128'(usage_o), 128'(7));
      check("fullpp_overflow", 128'(overflow_o), 128'(1));
      flush1();

      // Half full streaming across pointer wrap.
      for (int i = 0; i < 4; i++) push(4'($urandom_range(1, 15)));
      for (int i = 0; i < 20; i++) begin
         b = rand_bundle(4'($urandom_range(1, 15)));
         do_cycle(1'b1, b.ivalids, 1'b1, 1'b0, b);
         check($sformatf("stream%0d_usage", i), 128'(usage_o), 128'(4));
      end
      flush1();

      // Usage 5 with overflow set, then flush beside push and pop.
      for (int i = 0; i < 8; i++) push(4'($urandom_range(1, 15)));
      push(4'b1111);
      for (int i = 0; i < 3; i++) pop1();
      check("pre_flush_usage", 128'(usage_o), 128'(5));
      check("pre_flush_overflow", 128'(overflow_o), 128'(1));
      do_cycle(1'b1, 4'b1111, 1'b1, 1'b1, rand_bundle(4'b1111));
      check("flush_usage", 128'(usage_o), 128'(0));
      check("flush_overflow", 128'(overflow_o), 128'(0));
      check("flush_valid", 128'(valid_o), 128'(0));
`ifdef UOP_BUNDLE_FIFO_STATS_EN
      check("flush_drop_cnt", 128'(drop_cnt_o), 128'(0));
      check("flush_hwm", 128'(hwm_o), 128'(0));
`endif

      // Randomized traffic, including null bundles and occasional flush.
      for (int i = 0; i < 400; i++) begin
         logic [3:0] m;
         m = ($urandom_range(0, 5) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
         do_cycle(1'($urandom_range(0, 3) != 0), m, 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 49) == 0), rand_bundle(m));
      end

      // Asynchronous reset mid-operation.
      for (int i = 0; i < 3; i++) push(4'($urandom_range(1, 15)));
      #2 rst_ni = 1'b0;
      #1;
      model_reset();
      check("arst_usage", 128'(usage_o), 128'(0));
      check("arst_valid", 128'(valid_o), 128'(0));
      check("arst_ivalids", 128'(ivalids_o), 128'(0));
      check("arst_ready", 128'(ready_o), 128'(1));
      #1 rst_ni = 1'b1;
      push(4'b0110);
      pop1();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
      $fatal(1);
   end

endmodule
